// File: rtl/reg_if_pkg.sv
// Shared definitions for the 100 MHz register-interface decoder: bus widths,
// slave-select field, default error data and FSM state encoding.
package reg_if_pkg;

  localparam int REG_IF_AW = 21;
  localparam int REG_IF_DW = 16;
  localparam int SEL_MSB   = 20;
  localparam int SEL_LSB   = 16;
  localparam int SEL_W     = SEL_MSB - SEL_LSB + 1;

  localparam logic [REG_IF_DW-1:0] ERR_DATA_DEF = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_if_to_cnt.sv
// Slave-response timeout counter: reset by start/clear, counts while enabled,
// saturates at TO_CYCLES-1 and flags expire in that cycle.
module reg_if_to_cnt #(
  parameter int TO_CYCLES = 1024
) (
  input  logic clk_100m,
  input  logic rst_100m,
  input  logic start,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TO_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Holds at the last value instead of wrapping so expire stays stable.
  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) begin
      cnt <= '0;
    end else if (start || clear) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CNT_LAST);

endmodule

// File: rtl/reg_if_dec_100m.sv
// Register-interface address decoder in the 100 MHz domain: one request to one
// of NUM_SLV slaves, local timeout, one-cycle response. Optional error status
// outputs under `define REG_IF_DEC_ERR_STATUS_EN.
module reg_if_dec_100m
  import reg_if_pkg::*;
#(
  parameter int                   NUM_SLV   = 4,
  parameter int                   TO_CYCLES = 1024,
  parameter logic [REG_IF_DW-1:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic                           clk_100m,
  input  logic                           rst_100m,
  input  logic                           time_out_flag,
  input  logic [REG_IF_AW-1:0]           reg_if_addr,
  input  logic [REG_IF_DW-1:0]           reg_if_wdata,
  input  logic                           reg_if_valid,
  input  logic                           reg_if_we,
  output logic [REG_IF_DW-1:0]           reg_if_rdata,
  output logic                           reg_if_ready,
  output logic [NUM_SLV-1:0]             slv_valid,
  output logic [REG_IF_DW-1:0]           slv_addr,
  output logic [REG_IF_DW-1:0]           slv_wdata,
  output logic                           slv_we,
  input  logic [NUM_SLV*REG_IF_DW-1:0]   slv_rdata,
  input  logic [NUM_SLV-1:0]             slv_ready
`ifdef REG_IF_DEC_ERR_STATUS_EN
  ,
  input  logic                           err_clr,
  output logic [7:0]                     err_cnt,
  output logic [REG_IF_AW-1:0]           err_addr
`endif
);

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     req_idx, idx_q;
  logic                 dec_ok;
  logic [NUM_SLV-1:0]   req_onehot;
  logic                 sel_ready;
  logic [REG_IF_DW-1:0] sel_rdata;
  logic                 accept, dec_err, hit, tmo, expire;
  logic [REG_IF_DW-1:0] resp_data, held_rdata;

  assign req_idx = reg_if_addr[SEL_MSB:SEL_LSB];
  assign dec_ok  = int'(req_idx) < NUM_SLV;

  // Inline decode: request one-hot and selected slave's ready/data.
  always_comb begin
    req_onehot = '0;
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      req_onehot[i] = (req_idx == SEL_W'(i));
      if (idx_q == SEL_W'(i)) begin
        sel_ready = slv_ready[i];
        sel_rdata = slv_rdata[REG_IF_DW*i +: REG_IF_DW];
      end
    end
  end

  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) state <= IDLE;
    else          state <= state_nxt;
  end

  // Abort outranks ready, which outranks the local timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    dec_err   = 1'b0;
    hit       = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (reg_if_valid) begin
          accept = 1'b1;
          if (dec_ok) begin
            state_nxt = ACCESS;
          end else begin
            dec_err   = 1'b1;
            state_nxt = RESP;
          end
        end
      end
      ACCESS: begin
        if (time_out_flag) begin
          state_nxt = IDLE;
        end else if (sel_ready) begin
          hit       = 1'b1;
          state_nxt = RESP;
        end else if (expire) begin
          tmo       = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  reg_if_to_cnt #(.TO_CYCLES(TO_CYCLES)) u_to_cnt (
    .clk_100m (clk_100m),
    .rst_100m (rst_100m),
    .start    (accept),
    .clear    (state != ACCESS),
    .en       (state == ACCESS),
    .expire   (expire)
  );

  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) begin
      slv_valid  <= '0;
      slv_addr   <= '0;
      slv_wdata  <= '0;
      slv_we     <= 1'b0;
      idx_q      <= '0;
      resp_data  <= '0;
      held_rdata <= '0;
    end else begin
      slv_valid <= '0;
      if (accept) begin
        slv_addr  <= reg_if_addr[REG_IF_DW-1:0];
        slv_wdata <= reg_if_wdata;
        slv_we    <= reg_if_we;
        idx_q     <= req_idx;
        slv_valid <= dec_ok ? req_onehot : '0;
      end
      if (dec_err || tmo) resp_data <= ERR_DATA;
      else if (hit)       resp_data <= slv_we ? '0 : sel_rdata;
      if (reg_if_ready)   held_rdata <= resp_data;
    end
  end

  // Pending data becomes visible only with a real ready pulse, so an abort in RESP leaves rdata unchanged.
  assign reg_if_ready = (state == RESP) && !time_out_flag;
  assign reg_if_rdata = reg_if_ready ? resp_data : held_rdata;

`ifdef REG_IF_DEC_ERR_STATUS_EN
  logic       drop;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign drop    = reg_if_valid && (state != IDLE);
  assign err_inc = {1'b0, dec_err | tmo} + {1'b0, drop};
  assign err_sum = {1'b0, err_cnt} + {7'b0, err_inc};

  // Dropped requests bump the count but never overwrite the recorded address.
  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) begin
      err_cnt  <= '0;
      err_addr <= '0;
    end else if (err_clr) begin
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (dec_err)  err_addr <= reg_if_addr;
      else if (tmo) err_addr <= {idx_q, slv_addr};
    end
  end
`endif

endmodule

// File: doc/reg_if_dec_100m.md
Name: reg_if_dec_100m

Overview:
- Sits in the 100 MHz domain, directly downstream of the 200M→100M register-interface clock-domain crossing.
- Takes the crossed single-cycle register request (addr/wdata/valid/we) and decodes addr[20:16] to one of NUM_SLV register slaves, then issues a one-cycle request to that slave.
- Waits for the slave's ready, enforces a local timeout, and returns a one-cycle ready pulse with registered read data to the CDC stage.

Parameters:
- NUM_SLV, 4, number of decoded slaves; legal range 1..32.
- TO_CYCLES, 1024, cycles to wait for slave ready before a local timeout response.
- ERR_DATA, 16'hDEAD, read data returned on decode error or local timeout.

Ports:
- clk_100m  in  1  100 MHz clock.
- rst_100m  in  1  asynchronous, active-high reset.
- time_out_flag  in  1  upstream abort from the 200M master, pulse or level.
- reg_if_addr  in  21  request address: [20:16] selects the slave, [15:0] is the slave-local address.
- reg_if_wdata  in  16  write data.
- reg_if_valid  in  1  one-cycle request pulse.
- reg_if_we  in  1  1 = write, 0 = read; sampled together with valid.
- reg_if_rdata  out  16  response read data.
- reg_if_ready  out  1  one-cycle response pulse.
- slv_valid  out  NUM_SLV  one-hot request pulse to the selected slave.
- slv_addr  out  16  slave-local address.
- slv_wdata  out  16  slave write data.
- slv_we  out  1  slave write enable.
- slv_rdata  in  NUM_SLV*16  flattened slave read data; slave i drives bits [16i+15:16i].
- slv_ready  in  NUM_SLV  per-slave ready pulse.

Behaviour:
- Interface: one clock (clk_100m); reset rst_100m is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Registered request fields:
  - slv_addr, slv_wdata and slv_we are registered on an accepted request and held until the next accepted request.
  - reg_if_rdata is registered and held until the next response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On reg_if_valid, latch addr, wdata, we and the slave index idx = addr[20:16].
  - If idx < NUM_SLV: go to ACCESS, and drive slv_valid[idx] = 1 for exactly the first ACCESS cycle (cycle N+1, where N is the valid cycle).
  - If idx >= NUM_SLV (decode error): go to RESP with rdata = ERR_DATA; slv_valid is never asserted.
- ACCESS:
  - The counter starts at 0 in the slv_valid cycle and increments each cycle.
  - slv_ready[idx] = 1: capture slv_rdata slice idx, or 16'h0000 for a write, then go to RESP.
  - Counter reaches TO_CYCLES-1 without ready: capture ERR_DATA, then go to RESP.
  - slv_ready from a non-selected slave is ignored.
- RESP: reg_if_ready = 1 for exactly one cycle, then return to IDLE.
- Latency:
  - Fastest read: valid at N, slv_valid at N+1, slv_ready at N+1, reg_if_ready at N+2.
  - Decode error: reg_if_ready at N+1.
- Abort: time_out_flag = 1 in ACCESS or RESP goes to IDLE immediately, with no reg_if_ready pulse and rdata unchanged. In IDLE it is ignored.
- Simultaneous events:
  - slv_ready in the timeout cycle: ready wins and slave data is returned.
  - time_out_flag together with slv_ready: abort wins.
  - reg_if_valid together with time_out_flag in IDLE: the request is accepted.
- Busy overlap: reg_if_valid while not in IDLE is dropped; no queueing.
- Reset mid-transaction returns to IDLE; any pending response is lost.
- The counter width is clog2(TO_CYCLES)+1 and it does not wrap.

Optional Feature:
- Macro: REG_IF_DEC_ERR_STATUS_EN.
- Defined adds outputs:
  - err_cnt [7:0]: saturating count of decode errors, timeouts and dropped requests.
  - err_addr [20:0]: address of the most recent error request.
  - err_clr [1 in]: synchronous clear of both.
  - A dropped request's address is not recorded.
- Undefined: no ports, no counters, and no effect on any other behaviour.

Decomposition:
- Shared package reg_if_pkg holds:
  - REG_IF_AW = 21 and REG_IF_DW = 16;
  - the slave-select field range 20:16;
  - default ERR_DATA;
  - the FSM state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2).
- One sub-module, reg_if_to_cnt: a counter with start/clear/expire signals, parameterised by TO_CYCLES.
- The decode mux stays inline.

Test Plan:
- Read from slave 2, addr 21'h2_0010, with slave 2 ready one cycle after slv_valid returning 16'h1234 → slv_valid = 4'b0100 for one cycle, slv_addr = 16'h0010, reg_if_ready one cycle later with rdata = 16'h1234.
- Write to slave 0, addr 21'h0_0004, wdata 16'hA5A5, ready immediate → slv_we = 1, slv_wdata = 16'hA5A5, reg_if_ready at N+2, rdata = 16'h0000.
- Addr 21'h1F_0000 with NUM_SLV = 4 → no slv_valid, reg_if_ready at N+1 with rdata = 16'hDEAD.
- Slave never ready, TO_CYCLES = 16 → reg_if_ready exactly 17 cycles after valid with rdata = 16'hDEAD; a slv_ready in the final counter cycle returns slave data instead.
- time_out_flag 5 cycles into ACCESS → back to IDLE, no reg_if_ready; a new request 2 cycles later completes normally.
- reg_if_valid pulsed while in ACCESS, and rst_100m asserted mid-ACCESS → second request dropped (err_cnt +1 with the macro defined); reset drives all outputs to 0 asynchronously.
